cmd_scheduler: RTL
==================

Name: cmd_scheduler

Overview:
- Queues keypad commands and issues them one at a time on the calculator `cmd` input.
- Paces issue by the calculator `status` handshake; a new command goes out only when the calculator reports ready.
- Handles the error state by discarding queued keys until a clear command is seen.
- Sits between the keypad debouncer and the calculator core inside the calculator top level.

Parameters:
- DEPTH, 8, FIFO entries; power of two, at least 2.
- ACK_WIN, 2, cycles to wait for BUSY after an issue before treating the command as complete.
- DROP_W, 8, width of the saturating drop counter.

Ports:
- clock  in  1  system clock, rising edge.
- reset  in  1  asynchronous, active-low reset.
- key_valid  in  1  keypad offers a command this cycle.
- key_cmd  in  4  offered command code.
- key_ready  out  1  scheduler accepts the key this cycle.
- status  in  2  calculator status.
- cmd  out  4  registered command to the calculator; CMD_NOP when idle.
- level  out  $clog2(DEPTH)+1  FIFO occupancy.
- sched_busy  out  1  high when the state is not IDLE or the FIFO is not empty.
- drop_cnt  out  DROP_W  saturating count of keys discarded in the ERR state.

Behaviour:
- Reset: asynchronous, active-low, and takes effect immediately, including mid-operation. It sets:
  - FIFO emptied, level=0.
  - state=IDLE.
  - cmd=CMD_NOP.
  - drop_cnt=0.
  - key_ready=1, sched_busy=0.
- Handshake:
  - A key is accepted on an edge where key_valid and key_ready are both high.
  - key_ready = (level<DEPTH) in every state except ERR; in ERR it is constantly 1.
  - key_ready uses the registered level. When the FIFO is full, a simultaneous pop does not allow a push in the same cycle; the source holds key_valid.
- FIFO: circular buffer with head and tail pointers wrapping at DEPTH. Push and pop in the same cycle leaves level unchanged.
- FSM states: IDLE, ISSUE, WAIT_ACK, WAIT_DONE, ERR.
  - IDLE:
    - cmd=CMD_NOP.
    - If status==ST_ERROR, go to ERR.
    - Else if the FIFO is not empty and status==ST_READY, go to ISSUE and load cmd with the FIFO head.
  - ISSUE:
    - cmd holds the command for exactly one cycle.
    - Pop the FIFO, clear cmd to CMD_NOP at the next edge, load the window counter with ACK_WIN, and go to WAIT_ACK.
  - WAIT_ACK, evaluated in this priority order:
    - status==ST_ERROR: go to ERR.
    - status==ST_BUSY: go to WAIT_DONE.
    - Otherwise decrement the window counter; when it reaches 0, go to IDLE (command completed instantly).
  - WAIT_DONE:
    - status==ST_READY: go to IDLE.
    - status==ST_ERROR: go to ERR.
  - ERR:
    - The FIFO is flushed on entry.
    - Accepted keys other than CMD_CLR are discarded and increment drop_cnt, which saturates at all-ones.
    - An accepted CMD_CLR is loaded straight into cmd; the next state is ISSUE with the pop suppressed, then WAIT_ACK.
    - A CMD_CLR arriving on the same edge as the ERR entry is discarded (counted as a drop).
- Latency: a key accepted at edge N, with the scheduler in IDLE, the FIFO empty and status==ST_READY, appears on cmd in the cycle after edge N+1, for exactly one cycle.
- Commands are issued in FIFO order with no reordering and no duplication. At most one command is outstanding at any time.
- sched_busy is derived combinationally from the registered state and level.

Decomposition:
- Package calc_pkg holds:
  - The status constants: ST_READY=2'd0, ST_BUSY=2'd1, ST_ERROR=2'd2.
  - The command constants: CMD_NOP=4'hF, CMD_CLR=4'hE.
  - The state enum sched_state_t.
- Sub-module cmd_fifo: a parameterised synchronous FIFO with push, pop, head, level, full, empty and flush.
- The FSM and drop counter stay in cmd_scheduler.

Test Plan:
- Reset then idle: release reset with status=0 -> cmd=4'hF, level=0, key_ready=1, sched_busy=0, drop_cnt=0. Then assert reset mid-WAIT_DONE -> all of these values return immediately.
- Single issue with BUSY handshake:
  - Push key 4'h3 at edge N with status=0 -> cmd=4'h3 for exactly one cycle after edge N+1.
  - Drive status=1 for 3 cycles, then 0 -> the next queued key issues only after status returns to 0.
- Fast completion: status held at 0 throughout; push 4'h1, 4'h2, 4'h4 -> cmd pulses 1, 2, 4 in order, each pulse separated by ACK_WIN+1 NOP cycles.
- Full FIFO: with status held at 1, push 9 keys -> the first 8 are accepted, level=8, key_ready=0, and the 9th is held. Then set status=0 -> the 9th key is accepted only after the first pop.
- Error flush: queue 3 keys, then drive status=2 during WAIT_DONE -> level=0. Then push 4'h5 and 4'h6 -> drop_cnt=2 and neither is issued. Then push 4'hE -> cmd=4'hE for one cycle, followed by the WAIT_ACK behaviour.
- Drop saturation: with DROP_W=2, discard 5 keys in ERR -> drop_cnt=3 and no wrap.

Source files
------------

// File: rtl/calc_pkg.sv
// Shared calculator constants: status codes, command codes and the scheduler state type.
package calc_pkg;

    localparam logic [1:0] ST_READY = 2'd0;
    localparam logic [1:0] ST_BUSY  = 2'd1;
    localparam logic [1:0] ST_ERROR = 2'd2;

    localparam logic [3:0] CMD_NOP  = 4'hF;
    localparam logic [3:0] CMD_CLR  = 4'hE;

    typedef enum logic [2:0] {
        IDLE      = 3'd0,
        ISSUE     = 3'd1,
        WAIT_ACK  = 3'd2,
        WAIT_DONE = 3'd3,
        ERR       = 3'd4
    } sched_state_t;

endpackage

// File: rtl/cmd_fifo.sv
// Synchronous circular-buffer FIFO with flush; push is ignored when full, pop when empty.
module cmd_fifo #(
    parameter int unsigned DEPTH = 8,
    parameter int unsigned WIDTH = 4
) (
    input  logic                     clock,
    input  logic                     reset,
    input  logic                     i_push,
    input  logic                     i_pop,
    input  logic                     i_flush,
    input  logic [WIDTH-1:0]         i_din,
    output logic [WIDTH-1:0]         o_head,
    output logic [$clog2(DEPTH):0]   o_level,
    output logic                     o_full,
    output logic                     o_empty
);

    localparam int unsigned AW = $clog2(DEPTH);
    localparam logic [AW:0] LVL_FULL = (AW + 1)'(DEPTH);

    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [AW-1:0]    r_head;
    logic [AW-1:0]    r_tail;
    logic [AW:0]      r_level;
    logic             w_push;
    logic             w_pop;

    assign o_full  = (r_level == LVL_FULL);
    assign o_empty = (r_level == '0);
    assign w_push  = i_push && !o_full;
    assign w_pop   = i_pop && !o_empty;
    assign o_head  = r_mem[r_head];
    assign o_level = r_level;

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            r_head  <= '0;
            r_tail  <= '0;
            r_level <= '0;
        end else if (i_flush) begin
            r_head  <= '0;
            r_tail  <= '0;
            r_level <= '0;
        end else begin
            if (w_push) r_tail <= r_tail + 1'b1;
            if (w_pop)  r_head <= r_head + 1'b1;
            case ({w_push, w_pop})
                2'b10:   r_level <= r_level + 1'b1;
                2'b01:   r_level <= r_level - 1'b1;
                default: r_level <= r_level;
            endcase
        end
    end

    // Storage needs no reset: entries are only read once the level covers them.
    always_ff @(posedge clock) begin
        if (w_push && !i_flush) r_mem[r_tail] <= i_din;
    end

endmodule

// File: rtl/cmd_scheduler.sv
// Queues keypad commands and issues them one at a time, paced by the calculator status
// handshake; in the error state keys are discarded until a clear command arrives.
module cmd_scheduler
    import calc_pkg::*;
#(
    parameter int unsigned DEPTH   = 8,
    parameter int unsigned ACK_WIN = 2,
    parameter int unsigned DROP_W  = 8
) (
    input  logic                     clock,
    input  logic                     reset,
    input  logic                     key_valid,
    input  logic [3:0]               key_cmd,
    output logic                     key_ready,
    input  logic [1:0]               status,
    output logic [3:0]               cmd,
    output logic [$clog2(DEPTH):0]   level,
    output logic                     sched_busy,
    output logic [DROP_W-1:0]        drop_cnt
);

    localparam int unsigned WIN_W = (ACK_WIN < 2) ? 1 : $clog2(ACK_WIN + 1);
    localparam logic [WIN_W-1:0] WIN_INIT = WIN_W'(ACK_WIN);
    localparam logic [WIN_W-1:0] WIN_LAST = WIN_W'(1);

    sched_state_t             r_state;
    logic [3:0]               r_cmd;
    logic [WIN_W-1:0]         r_win;
    logic                     r_skip_pop;
    logic [DROP_W-1:0]        r_drop;

    logic                     w_accept;
    logic                     w_enter_err;
    logic                     w_push;
    logic                     w_pop;
    logic                     w_drop;
    logic                     w_clr;
    logic                     w_full;
    logic                     w_empty;
    logic [3:0]               w_head;
    logic [$clog2(DEPTH):0]   w_level;

    cmd_fifo #(
        .DEPTH (DEPTH),
        .WIDTH (4)
    ) u_fifo (
        .clock   (clock),
        .reset   (reset),
        .i_push  (w_push),
        .i_pop   (w_pop),
        .i_flush (w_enter_err),
        .i_din   (key_cmd),
        .o_head  (w_head),
        .o_level (w_level),
        .o_full  (w_full),
        .o_empty (w_empty)
    );

    assign key_ready  = (r_state == ERR) || !w_full;
    assign w_accept   = key_valid && key_ready;

    // A key accepted on the edge that enters ERR is flushed with the queue, so count it as dropped.
    assign w_enter_err = (status == ST_ERROR) &&
                         ((r_state == IDLE) || (r_state == WAIT_ACK) || (r_state == WAIT_DONE));
    assign w_push      = w_accept && (r_state != ERR) && !w_enter_err;
    assign w_clr       = w_accept && (r_state == ERR) && (key_cmd == CMD_CLR);
    assign w_drop      = w_accept && (((r_state == ERR) && (key_cmd != CMD_CLR)) || w_enter_err);
    assign w_pop       = (r_state == ISSUE) && !r_skip_pop;

    assign cmd        = r_cmd;
    assign level      = w_level;
    assign drop_cnt   = r_drop;
    assign sched_busy = (r_state != IDLE) || (w_level != '0);

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            r_drop <= '0;
        end else if (w_drop && (r_drop != '1)) begin
            r_drop <= r_drop + 1'b1;
        end
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            r_state    <= IDLE;
            r_cmd      <= CMD_NOP;
            r_win      <= '0;
            r_skip_pop <= 1'b0;
        end else begin
            case (r_state)
                IDLE: begin
                    r_cmd <= CMD_NOP;
                    if (status == ST_ERROR) begin
                        r_state <= ERR;
                    end else if (!w_empty && (status == ST_READY)) begin
                        r_state    <= ISSUE;
                        r_cmd      <= w_head;
                        r_skip_pop <= 1'b0;
                    end
                end
                ISSUE: begin
                    r_cmd      <= CMD_NOP;
                    r_win      <= WIN_INIT;
                    r_skip_pop <= 1'b0;
                    r_state    <= WAIT_ACK;
                end
                WAIT_ACK: begin
                    if (status == ST_ERROR) begin
                        r_state <= ERR;
                    end else if (status == ST_BUSY) begin
                        r_state <= WAIT_DONE;
                    end else begin
                        r_win <= r_win - 1'b1;
                        if (r_win <= WIN_LAST) r_state <= IDLE;
                    end
                end
                WAIT_DONE: begin
                    if (status == ST_READY) begin
                        r_state <= IDLE;
                    end else if (status == ST_ERROR) begin
                        r_state <= ERR;
                    end
                end
                ERR: begin
                    r_cmd <= CMD_NOP;
                    // The clear bypasses the queue, so its ISSUE cycle must not pop.
                    if (w_clr) begin
                        r_cmd      <= CMD_CLR;
                        r_skip_pop <= 1'b1;
                        r_state    <= ISSUE;
                    end
                end
                default: begin
                    r_cmd   <= CMD_NOP;
                    r_state <= IDLE;
                end
            endcase
        end
    end

endmodule
